mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage of the five-stage Y86-64 pipeline plus the M→W pipeline register; it consumes the M-register outputs and produces W-register outputs for register-file writeback.
- Computes the data address and read/write enables, and owns the byte-addressed data memory.
- Produces `m_stat` and `m_valM` for forwarding and pipeline control.
- Holds the sticky processor status.

Parameters:
- MEM_BYTES, 8192, data memory size in bytes.
- AW, 64, address width; addresses are full 64-bit `valE`/`valA`.

Ports:
- clk in 1: clock; all state updates on posedge.
- rst in 1: synchronous active-high reset.
- M_stat in 3: status from M register.
- M_icode in 4: icode from M register.
- M_cnd in 1: condition from M register; passed through, unused internally.
- M_valE in 64: ALU result.
- M_valA in 64: store data / pop-ret address.
- M_dstE in 4: destination E.
- M_dstM in 4: destination M.
- W_stall in 1: hold W register.
- W_bubble in 1: load bubble into W register.
- m_stat out 3: combinational memory-stage status.
- m_valM out 64: combinational read data.
- W_stat out 3, W_icode out 4, W_valE out 64, W_valM out 64, W_dstE out 4, W_dstM out 4: W register outputs.
- proc_stat out 3: sticky processor status.
- dmem_error out 1: combinational address-fault flag.

Behaviour:
- Constants:
  - Stat: AOK=1, HLT=2, ADR=3, INS=4.
  - Icode: HALT=0, NOP=1, RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - RNONE=F.
- Address: RMMOVQ/PUSHQ/CALL/MRMOVQ use `M_valE`; POPQ/RET use `M_valA`; otherwise don't-care, with enables low.
- mem_read = icode ∈ {MRMOVQ, POPQ, RET}.
- mem_write = icode ∈ {RMMOVQ, PUSHQ, CALL}.
- Write data is always `M_valA`.
- Memory access:
  - 8 bytes, little-endian: byte `addr` is bits [7:0].
  - Read is combinational from current contents.
  - Write commits at posedge.
- dmem_error = (mem_read | mem_write) & (addr > MEM_BYTES-8). Compare the full 64-bit unsigned value, so no wrap-around. Addr = MEM_BYTES-8 is legal; MEM_BYTES-7 faults.
- On dmem_error:
  - The write is suppressed entirely; no partial bytes are written.
  - m_valM = 0.
  - m_stat = ADR.
- Otherwise m_stat = M_stat.
- m_valM = 0 when mem_read=0.
- Writes are independent of W_stall/W_bubble. Pipeline control bubbles M after an exception, so a faulting or post-halt store never reaches this stage with a valid write.
- W register, priority rst > W_bubble > W_stall > load:
  - Reset/bubble value: W_stat=AOK, W_icode=NOP, W_valE=0, W_valM=0, W_dstE=RNONE, W_dstM=RNONE.
  - Stall holds all fields.
  - Load value: W_stat←m_stat, W_icode←M_icode, W_valE←M_valE, W_valM←m_valM, W_dstE←M_dstE, W_dstM←M_dstM.
  - W_bubble and W_stall both high → bubble.
- proc_stat:
  - Reset value AOK.
  - At posedge, if proc_stat==AOK and W_stat≠AOK, proc_stat←W_stat.
  - Once non-AOK it holds until rst, even if W_stat later returns to AOK.
- Latency: memory result is combinational in the M cycle; appears on W outputs one cycle later.
- Reset mid-operation: any write pending in the reset cycle is suppressed (rst gates mem_write). Memory contents are not cleared by rst.
- Memory is initialised by testbench or `$readmemh` only.

Decomposition:
- Package y86_pkg: stat codes, icode constants, RNONE, and a reg-id width of 4.
- Sub-module data_mem: byte array of MEM_BYTES, with combinational 8-byte read, synchronous 8-byte write with write-enable, and range check producing the error.
- The stage instantiates data_mem and contains the address/enable logic, the W register and the proc_stat register.

Test Plan:
1. Store then load: RMMOVQ with M_valE=0x100, M_valA=0x1122334455667788; next cycle MRMOVQ with M_valE=0x100 → m_valM=0x1122334455667788, byte 0x100=0x88; next edge W_valM matches and W_stat=AOK.
2. Stack ops:
   - PUSHQ with M_valE=0x1F00, M_valA=5.
   - Then POPQ with M_valA=0x1F00 → m_valM=5.
   - CALL with M_valE=0x1EF8, M_valA=0x40, then RET with M_valA=0x1EF8 → m_valM=0x40.
3. Boundary: MRMOVQ at addr 8184 → no error; at 8185 → dmem_error=1, m_stat=3, m_valM=0. RMMOVQ at 0xFFFFFFFFFFFFFFF8 → error, and memory at bytes 8184..8191 is unchanged.
4. Stall/bubble:
   - Load NOP, then assert W_stall for 2 cycles while inputs change → W outputs frozen.
   - W_bubble plus W_stall → W_icode=1, W_dstE=F.
5. Sticky status:
   - HLT (M_stat=2) reaches W → proc_stat=2 one edge later.
   - A subsequent ADR is ignored and proc_stat stays 2.
   - rst → proc_stat=1 and W register at bubble values.
6. Reset-gated write: RMMOVQ to 0x200 with rst=1 in the same cycle → memory at 0x200 unchanged; OPQ (icode 6) → mem_read=mem_write=0 and m_valM=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Y86-64 shared constants: status codes, memory-stage icodes, register-id width.
package y86_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [REG_W-1:0] RNONE = 4'hF;

endpackage

// File: rtl/mem_wb_stage_if.sv
// M-register inputs, pipeline control, and memory-stage / W-register outputs.
interface mem_wb_if;
  import y86_pkg::*;

  logic [2:0]       M_stat;
  logic [3:0]       M_icode;
  logic             M_cnd;
  logic [63:0]      M_valE;
  logic [63:0]      M_valA;
  logic [REG_W-1:0] M_dstE;
  logic [REG_W-1:0] M_dstM;
  logic             W_stall;
  logic             W_bubble;

  logic [2:0]       m_stat;
  logic [63:0]      m_valM;
  logic [2:0]       W_stat;
  logic [3:0]       W_icode;
  logic [63:0]      W_valE;
  logic [63:0]      W_valM;
  logic [REG_W-1:0] W_dstE;
  logic [REG_W-1:0] W_dstM;
  logic [2:0]       proc_stat;
  logic             dmem_error;

  modport master (
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    input  m_stat, m_valM, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
           proc_stat, dmem_error
  );

  modport slave (
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
    output m_stat, m_valM, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
           proc_stat, dmem_error
  );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Byte-addressed little-endian data memory: combinational 8-byte read,
// posedge 8-byte write, and a full-width range check that blocks faulting accesses.
module data_mem #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned AW        = 64
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_re,
  input  logic          i_we,
  input  logic          i_wr_en,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata,
  output logic          o_err
);

  localparam int unsigned IW = $clog2(MEM_BYTES);
  localparam logic [AW-1:0] LIMIT = AW'(MEM_BYTES - 8);

  logic [7:0]    r_mem [MEM_BYTES];
  logic [IW-1:0] w_base;
  logic [63:0]   w_raw;

  assign w_base = i_addr[IW-1:0];
  // Unsigned compare over the whole address so huge addresses never alias low memory.
  assign o_err  = (i_re | i_we) & (i_addr > LIMIT);

  always_comb begin
    w_raw = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_raw[8*i +: 8] = r_mem[w_base + IW'(i)];
    end
  end

  assign o_rdata = (i_re && !o_err) ? w_raw : '0;

  always_ff @(posedge clk) begin
    if (i_we && i_wr_en && !o_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_mem[w_base + IW'(i)] <= i_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Y86-64 memory stage plus M->W pipeline register and sticky processor status.
module mem_wb_stage
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned AW        = 64
) (
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  logic          w_mem_read;
  logic          w_mem_write;
  logic [AW-1:0] w_addr;
  logic [63:0]   w_rdata;
  logic          w_err;
  logic [2:0]    w_m_stat;

  logic [2:0]       r_W_stat;
  logic [3:0]       r_W_icode;
  logic [63:0]      r_W_valE;
  logic [63:0]      r_W_valM;
  logic [REG_W-1:0] r_W_dstE;
  logic [REG_W-1:0] r_W_dstM;
  logic [2:0]       r_proc_stat;

  assign w_mem_read  = bus.M_icode inside {I_MRMOVQ, I_POPQ, I_RET};
  assign w_mem_write = bus.M_icode inside {I_RMMOVQ, I_PUSHQ, I_CALL};

  always_comb begin
    w_addr = '0;
    case (bus.M_icode)
      I_RMMOVQ, I_PUSHQ, I_CALL, I_MRMOVQ: w_addr = bus.M_valE[AW-1:0];
      I_POPQ, I_RET:                       w_addr = bus.M_valA[AW-1:0];
      default:                             w_addr = '0;
    endcase
  end

  data_mem #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_dmem (
    .clk     (clk),
    .i_addr  (w_addr),
    .i_re    (w_mem_read),
    .i_we    (w_mem_write),
    .i_wr_en (~rst),
    .i_wdata (bus.M_valA),
    .o_rdata (w_rdata),
    .o_err   (w_err)
  );

  assign w_m_stat       = w_err ? STAT_ADR : bus.M_stat;
  assign bus.m_stat     = w_m_stat;
  assign bus.m_valM     = w_rdata;
  assign bus.dmem_error = w_err;

  always_ff @(posedge clk) begin
    if (rst || bus.W_bubble) begin
      r_W_stat  <= STAT_AOK;
      r_W_icode <= I_NOP;
      r_W_valE  <= '0;
      r_W_valM  <= '0;
      r_W_dstE  <= RNONE;
      r_W_dstM  <= RNONE;
    end else if (!bus.W_stall) begin
      r_W_stat  <= w_m_stat;
      r_W_icode <= bus.M_icode;
      r_W_valE  <= bus.M_valE;
      r_W_valM  <= w_rdata;
      r_W_dstE  <= bus.M_dstE;
      r_W_dstM  <= bus.M_dstM;
    end
  end

  // First non-AOK status seen in W is latched until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proc_stat <= STAT_AOK;
    end else if (r_proc_stat == STAT_AOK && r_W_stat != STAT_AOK) begin
      r_proc_stat <= r_W_stat;
    end
  end

  assign bus.W_stat    = r_W_stat;
  assign bus.W_icode   = r_W_icode;
  assign bus.W_valE    = r_W_valE;
  assign bus.W_valM    = r_W_valM;
  assign bus.W_dstE    = r_W_dstE;
  assign bus.W_dstM    = r_W_dstM;
  assign bus.proc_stat = r_proc_stat;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mem_wb_if bus ();

  mem_wb_stage #(
    .MEM_BYTES (8192),
    .AW        (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.M_stat  = st;
    bus.M_icode = ic;
    bus.M_cnd   = 1'b0;
    bus.M_valE  = ve;
    bus.M_valA  = va;
    bus.M_dstE  = de;
    bus.M_dstM  = dm;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.W_stall = 1'b0;
    bus.W_bubble = 1'b0;
    set_m(3'd1, 4'h6, 64'h55, 64'h0, 4'h3, 4'h4);
    @(posedge clk); #1;
    n_total++;
    if (bus.W_icode !== 4'h1) $display("FAIL reset_W_icode got %0h want 1", bus.W_icode);
    else n_pass++;
    n_total++;
    if (bus.W_stat !== 3'd1) $display("FAIL reset_W_stat got %0d want 1", bus.W_stat);
    else n_pass++;
    n_total++;
    if (bus.W_dstE !== 4'hF || bus.W_dstM !== 4'hF || bus.W_valE !== 64'h0)
      $display("FAIL reset_W_fields got dstE=%0h dstM=%0h valE=%0h want F F 0",
               bus.W_dstE, bus.W_dstM, bus.W_valE);
    else n_pass++;
    n_total++;
    if (bus.proc_stat !== 3'd1) $display("FAIL reset_proc_stat got %0d want 1", bus.proc_stat);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    @(negedge clk);
    set_m(3'd1, 4'h4, 64'h100, 64'h1122334455667788, 4'hF, 4'hF);
    @(posedge clk); #1;
    n_total++;
    if (dut.u_dmem.r_mem[256] !== 8'h88)
      $display("FAIL store_byte0 got %0h want 88", dut.u_dmem.r_mem[256]);
    else n_pass++;
    @(negedge clk);
    set_m(3'd1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h2);
    #1;
    n_total++;
    if (bus.m_valM !== 64'h1122334455667788)
      $display("FAIL load_m_valM got %0h want 1122334455667788", bus.m_valM);
    else n_pass++;
    n_total++;
    if (bus.dmem_error !== 1'b0 || bus.m_stat !== 3'd1)
      $display("FAIL load_status got err=%0b stat=%0d want 0 1", bus.dmem_error, bus.m_stat);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.W_valM !== 64'h1122334455667788 || bus.W_stat !== 3'd1 ||
        bus.W_icode !== 4'h5 || bus.W_dstM !== 4'h2)
      $display("FAIL load_W got valM=%0h stat=%0d icode=%0h dstM=%0h want 1122334455667788 1 5 2",
               bus.W_valM, bus.W_stat, bus.W_icode, bus.W_dstM);
    else n_pass++;
  endtask

  task automatic test_stack();
    @(negedge clk);
    set_m(3'd1, 4'hA, 64'h1F00, 64'h5, 4'h4, 4'hF);
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'hB, 64'h1F08, 64'h1F00, 4'h4, 4'h1);
    #1;
    n_total++;
    if (bus.m_valM !== 64'h5) $display("FAIL popq_m_valM got %0h want 5", bus.m_valM);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h8, 64'h1EF8, 64'h40, 4'h4, 4'hF);
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h9, 64'h1F00, 64'h1EF8, 4'h4, 4'hF);
    #1;
    n_total++;
    if (bus.m_valM !== 64'h40) $display("FAIL ret_m_valM got %0h want 40", bus.m_valM);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_boundary();
    @(negedge clk);
    set_m(3'd1, 4'h4, 64'd8184, 64'hA5A5_0102_0304_5A5A, 4'hF, 4'hF);
    #1;
    n_total++;
    if (bus.dmem_error !== 1'b0) $display("FAIL store_8184_err got %0b want 0", bus.dmem_error);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h5, 64'd8184, 64'h0, 4'hF, 4'h3);
    #1;
    n_total++;
    if (bus.dmem_error !== 1'b0 || bus.m_valM !== 64'hA5A5_0102_0304_5A5A)
      $display("FAIL load_8184 got err=%0b valM=%0h want 0 a5a501020304 5a5a", bus.dmem_error, bus.m_valM);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h5, 64'd8185, 64'h0, 4'hF, 4'h3);
    #1;
    n_total++;
    if (bus.dmem_error !== 1'b1 || bus.m_stat !== 3'd3 || bus.m_valM !== 64'h0)
      $display("FAIL load_8185 got err=%0b stat=%0d valM=%0h want 1 3 0",
               bus.dmem_error, bus.m_stat, bus.m_valM);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.W_stat !== 3'd3 || bus.W_valM !== 64'h0)
      $display("FAIL load_8185_W got stat=%0d valM=%0h want 3 0", bus.W_stat, bus.W_valM);
    else n_pass++;
    @(negedge clk);
    set_m(3'd1, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 4'hF, 4'hF);
    #1;
    n_total++;
    if (bus.dmem_error !== 1'b1 || bus.m_stat !== 3'd3)
      $display("FAIL store_wrap_err got err=%0b stat=%0d want 1 3", bus.dmem_error, bus.m_stat);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h5, 64'd8184, 64'h0, 4'hF, 4'h3);
    #1;
    n_total++;
    if (bus.m_valM !== 64'hA5A5_0102_0304_5A5A)
      $display("FAIL store_wrap_unchanged got %0h want a5a5010203045a5a", bus.m_valM);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_stall_bubble();
    @(negedge clk);
    rst = 1'b1;
    set_m(3'd1, 4'h1, 64'h77, 64'h0, 4'h3, 4'h4);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (bus.W_icode !== 4'h1 || bus.W_valE !== 64'h77 || bus.W_dstE !== 4'h3)
      $display("FAIL nop_load got icode=%0h valE=%0h dstE=%0h want 1 77 3",
               bus.W_icode, bus.W_valE, bus.W_dstE);
    else n_pass++;
    @(negedge clk);
    bus.W_stall = 1'b1;
    set_m(3'd1, 4'h6, 64'h99, 64'h0, 4'h2, 4'hF);
    @(posedge clk);
    @(negedge clk);
    set_m(3'd2, 4'h0, 64'hAA, 64'h0, 4'h5, 4'h6);
    @(posedge clk); #1;
    n_total++;
    if (bus.W_icode !== 4'h1 || bus.W_valE !== 64'h77 || bus.W_dstE !== 4'h3 ||
        bus.W_dstM !== 4'h4 || bus.W_stat !== 3'd1)
      $display("FAIL stall_hold got icode=%0h valE=%0h dstE=%0h dstM=%0h stat=%0d want 1 77 3 4 1",
               bus.W_icode, bus.W_valE, bus.W_dstE, bus.W_dstM, bus.W_stat);
    else n_pass++;
    @(negedge clk);
    bus.W_bubble = 1'b1;
    set_m(3'd1, 4'h6, 64'h99, 64'h0, 4'h2, 4'hF);
    @(posedge clk); #1;
    n_total++;
    if (bus.W_icode !== 4'h1 || bus.W_dstE !== 4'hF || bus.W_valE !== 64'h0)
      $display("FAIL bubble_over_stall got icode=%0h dstE=%0h valE=%0h want 1 F 0",
               bus.W_icode, bus.W_dstE, bus.W_valE);
    else n_pass++;
    @(negedge clk);
    bus.W_stall = 1'b0;
    bus.W_bubble = 1'b0;
  endtask

  task automatic test_sticky();
    @(negedge clk);
    set_m(3'd2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    @(posedge clk); #1;
    n_total++;
    if (bus.W_stat !== 3'd2 || bus.proc_stat !== 3'd1)
      $display("FAIL halt_in_W got W_stat=%0d proc=%0d want 2 1", bus.W_stat, bus.proc_stat);
    else n_pass++;
    @(negedge clk);
    set_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    @(posedge clk); #1;
    n_total++;
    if (bus.proc_stat !== 3'd2) $display("FAIL halt_sticky got %0d want 2", bus.proc_stat);
    else n_pass++;
    @(negedge clk);
    set_m(3'd3, 4'h6, 64'h0, 64'h0, 4'hF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    @(posedge clk); #1;
    n_total++;
    if (bus.proc_stat !== 3'd2) $display("FAIL adr_ignored got %0d want 2", bus.proc_stat);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    set_m(3'd3, 4'h5, 64'h10, 64'h0, 4'h2, 4'h3);
    @(posedge clk); #1;
    n_total++;
    if (bus.proc_stat !== 3'd1 || bus.W_stat !== 3'd1 || bus.W_icode !== 4'h1 ||
        bus.W_dstM !== 4'hF || bus.W_valM !== 64'h0)
      $display("FAIL rst_clears got proc=%0d stat=%0d icode=%0h dstM=%0h valM=%0h want 1 1 1 F 0",
               bus.proc_stat, bus.W_stat, bus.W_icode, bus.W_dstM, bus.W_valM);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_write();
    @(negedge clk);
    set_m(3'd1, 4'h4, 64'h200, 64'h0123_4567_89AB_CDEF, 4'hF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_m(3'd1, 4'h4, 64'h200, 64'hFFFF_0000_FFFF_0000, 4'hF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_m(3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h1);
    #1;
    n_total++;
    if (bus.m_valM !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL rst_gated_write got %0h want 0123456789abcdef", bus.m_valM);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_m(3'd1, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 4'hF);
    #1;
    n_total++;
    if (bus.m_valM !== 64'h0 || bus.dmem_error !== 1'b0 || bus.m_stat !== 3'd1)
      $display("FAIL opq_no_access got valM=%0h err=%0b stat=%0d want 0 0 1",
               bus.m_valM, bus.dmem_error, bus.m_stat);
    else n_pass++;
    @(posedge clk);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.W_stall = 1'b0;
    bus.W_bubble = 1'b0;
    set_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    test_reset();
    test_store_load();
    test_stack();
    test_boundary();
    test_stall_bubble();
    test_sticky();
    test_reset_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
